// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_trace_buffer
//  Purpose  : Circular instruction-retire trace buffer with four capture
//             modes (all cycles, register writes only, post-breakpoint
//             one-shot, off), show-ahead read port, sticky overflow and
//             breakpoint-triggered flags.
//  Ports    :
//     Clk                 system clock, all state updates on rising edge
//     Reset               synchronous active-low reset
//     en, clr, mode       capture enable, synchronous clear, capture mode
//     PC, instruction     retiring instruction's PC and encoding
//     RegWr, RD, WData    register write strobe, destination, write data
//     bp_en, bp_addr      breakpoint enable and breakpoint PC
//     rd_ready            consumer accepts the head entry
//     rd_valid, rd_*      show-ahead head entry
//     count               number of stored entries
//     overflow            sticky: an entry was overwritten
//     triggered           sticky: breakpoint hit
//  Revision : 1.0  initial release
// ============================================================================
module cpu_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int RA_W   = 5
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       en,
   input  logic                       clr,
   input  logic [1:0]                 mode,
   input  logic [DATA_W-1:0]          PC,
   input  logic [DATA_W-1:0]          instruction,
   input  logic                       RegWr,
   input  logic [RA_W-1:0]            RD,
   input  logic [DATA_W-1:0]          WData,
   input  logic                       bp_en,
   input  logic [DATA_W-1:0]          bp_addr,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_pc,
   output logic [DATA_W-1:0]          rd_instr,
   output logic [DATA_W-1:0]          rd_wdata,
   output logic                       rd_wr,
   output logic [RA_W-1:0]            rd_rd,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] MODE_ALL   = 2'b00;
   localparam logic [1:0] MODE_REGWR = 2'b01;
   localparam logic [1:0] MODE_TRIG  = 2'b10;
   localparam logic [1:0] MODE_OFF   = 2'b11;

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Entry storage: no reset, only pointers/count/flags are reset.
   logic [DATA_W-1:0] mem_pc    [DEPTH];
   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [DATA_W-1:0] mem_wdata [DEPTH];
   logic              mem_wr    [DEPTH];
   logic [RA_W-1:0]   mem_rd    [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          frozen;
   logic          hit;
   logic          cap;
   logic          pop;
   logic          full;
   logic [CW-1:0] count_next;

   always_comb begin
      hit  = en & bp_en & (PC == bp_addr);
      full = (count == FULL_COUNT);
      pop  = rd_valid & rd_ready;

      cap = 1'b0;
      case (mode)
         MODE_ALL:   cap = en;
         MODE_REGWR: cap = en & RegWr & (RD != '0);
         // The hit cycle itself is captured, so hit is ORed with the
         // registered trigger flag.
         MODE_TRIG:  cap = en & (triggered | hit) & ~frozen;
         MODE_OFF:   cap = 1'b0;
         default:    cap = 1'b0;
      endcase

      // A capture into a full buffer either replaces the popped slot or
      // overwrites the oldest entry; either way count stays at DEPTH.
      count_next = count;
      if (cap && !pop && !full) begin
         count_next = count + 1'b1;
      end else if (!cap && pop) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         triggered <= 1'b0;
         frozen    <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         triggered <= 1'b0;
         frozen    <= 1'b0;
      end else begin
         if (hit) begin
            triggered <= 1'b1;
         end
         if (cap) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         // When full, the write pointer sits on the oldest entry, so an
         // un-popped capture must push the read pointer past it.
         if (pop || (cap && full)) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (cap && full && !pop) begin
            overflow <= 1'b1;
         end
         count <= count_next;
         if ((mode == MODE_TRIG) && (count_next == FULL_COUNT)) begin
            frozen <= 1'b1;
         end
      end
   end

   // Storage write; a write during clr/reset is harmless because the
   // pointers and count are cleared on the same edge.
   always_ff @(posedge Clk) begin
      if (cap) begin
         mem_pc[wr_ptr]    <= PC;
         mem_instr[wr_ptr] <= instruction;
         mem_wdata[wr_ptr] <= WData;
         mem_wr[wr_ptr]    <= RegWr;
         mem_rd[wr_ptr]    <= RD;
      end
   end

   assign rd_valid = (count != '0);
   assign rd_pc    = mem_pc[rd_ptr];
   assign rd_instr = mem_instr[rd_ptr];
   assign rd_wdata = mem_wdata[rd_ptr];
   assign rd_wr    = mem_wr[rd_ptr];
   assign rd_rd    = mem_rd[rd_ptr];

endmodule
`default_nettype wire
